adc_capture_sequencer: RTL

Sequences one serial ADC conversion channel on the SPI clock domain: drives chip-select, counts SCLK bits per frame, extracts the data field from the serial stream, and writes each sample into the sample RAM at an auto-incrementing address.
It replaces the free-running counter/controller pairing with a start/abort/done handshake, so a host FSM can request bursts of N samples.
It sits between the SPI clock generator and the sample RAM.

---
 rtl/adc_capture_sequencer_pkg.sv | 28 ++
 rtl/adc_frame_shift.sv | 72 +++++++
 rtl/adc_capture_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/adc_capture_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_sequencer_pkg
//   Shared definitions for the ADC capture sequencer and its frame shifter:
//   the sequencer state type, default frame geometry and a counter-width
//   helper. No ports.
// ---------------------------------------------------------------------------
package adc_capture_sequencer_pkg;

   localparam int DEF_DATA_W       = 10;  // data bits per sample, MSB first
   localparam int DEF_FRAME_BITS   = 16;  // SCLK cycles with cs low per frame
   localparam int DEF_LEAD_ZEROS   = 4;   // leading zero bits before data
   localparam int DEF_QUIET_CYCLES = 2;   // cs-high cycles before each frame
   localparam int DEF_ADDR_W       = 4;   // sample RAM address width

   typedef enum logic [2:0] {
      IDLE,
      QUIET,
      CONV,
      WRITE,
      DONE
   } state_t;

   // Width of a counter that must hold the values 0..n-1 (at least 1 bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc_frame_shift.sv
// ---------------------------------------------------------------------------
// adc_frame_shift
//   Per-frame serial-to-parallel unit. Tracks the bit index inside a frame,
//   shifts the data field in MSB first and flags any leading bit that is 1.
//
// Ports:
//   clk      in   SPI-rate clock, rising edge
//   reset_b  in   asynchronous active-low reset
//   clear    in   restart the frame (asserted on the edge that enters CONV)
//   en       in   one serial bit is sampled this cycle (sequencer in CONV)
//   sdata    in   ADC serial data
//   last_bit out  this cycle samples the final bit of the frame
//   lead_one out  this cycle samples a leading bit that is 1
//   sample   out  assembled data field, including the bit sampled this cycle
// ---------------------------------------------------------------------------
module adc_frame_shift
   import adc_capture_sequencer_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int LEAD_ZEROS = DEF_LEAD_ZEROS
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              clear,
   input  logic              en,
   input  logic              sdata,
   output logic              last_bit,
   output logic              lead_one,
   output logic [DATA_W-1:0] sample
);

   localparam int IDX_W = cnt_width(FRAME_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
   localparam logic [IDX_W-1:0] DATA_LO  = IDX_W'(LEAD_ZEROS);
   localparam logic [IDX_W-1:0] DATA_HI  = IDX_W'(LEAD_ZEROS + DATA_W - 1);

   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              in_lead;
   logic              in_data;

   // NOTE: every output of this block is assigned on every path, so it stays
   // purely combinational and no latch is inferred.
   always_comb begin
      in_lead  = (bit_idx < DATA_LO);
      in_data  = (bit_idx >= DATA_LO) && (bit_idx <= DATA_HI);
      last_bit = en && (bit_idx == LAST_IDX);
      lead_one = en && in_lead && sdata;
      // Present the shift including the current bit, so a data field that
      // ends on the last frame bit is still complete when the frame closes.
      sample   = in_data ? {shreg[DATA_W-2:0], sdata} : shreg;
   end

   // NOTE: registers are written with non-blocking assignments so every
   // flop updates from the values present before the clock edge.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else if (clear) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else if (en) begin
         bit_idx <= bit_idx + IDX_W'(1);
         if (in_data) begin
            shreg <= sample;
         end
      end
   end

endmodule

// File: rtl/adc_capture_sequencer.sv
// ---------------------------------------------------------------------------
// adc_capture_sequencer
//   Runs bursts of ADC conversions on the SPI clock: drives chip-select,
//   collects each serial frame through adc_frame_shift and writes every
//   sample to the sample RAM at an auto-incrementing address. A host starts
//   a burst of num_samples conversions and gets busy/done back; abort ends
//   a burst early without writing a partial frame.
//
// Ports:
//   clk          in   SPI-rate clock (also forwarded as ADC SCLK)
//   reset_b      in   asynchronous active-low reset
//   start        in   level; accepted only in IDLE
//   abort        in   ends the burst at the next edge, beats start
//   num_samples  in   samples per burst, latched when start is accepted
//   adc_sdata    in   ADC serial data, sampled while cs is low
//   cs           out  ADC chip-select, active low
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when a burst completes
//   frame_err    out  sticky leading-bit error, cleared by an accepted start
//   wr_en        out  RAM write strobe, one cycle per sample
//   wr_addr      out  RAM write address
//   wr_data      out  RAM write data
// ---------------------------------------------------------------------------
module adc_capture_sequencer
   import adc_capture_sequencer_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int FRAME_BITS   = DEF_FRAME_BITS,
   parameter int LEAD_ZEROS   = DEF_LEAD_ZEROS,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
   parameter int ADDR_W       = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_samples,
   input  logic              adc_sdata,
   output logic              cs,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int QCNT_W = cnt_width(QUIET_CYCLES);
   localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(QUIET_CYCLES - 1);

   state_t            state;
   logic [QCNT_W-1:0] quiet_cnt;
   logic [CNT_W-1:0]  num_lat;
   logic [CNT_W-1:0]  sample_cnt;
   logic [CNT_W-1:0]  sample_cnt_inc;
   logic              quiet_last;
   logic              shift_en;
   logic              last_bit;
   logic              lead_one;
   logic [DATA_W-1:0] sample;

   assign quiet_last     = (state == QUIET) && (quiet_cnt == QUIET_LAST);
   assign shift_en       = (state == CONV);
   assign sample_cnt_inc = sample_cnt + CNT_W'(1);

   // The shifter restarts on the same edge that drops cs, so bit index 0
   // lines up with the first edge that samples adc_sdata with cs low.
   adc_frame_shift #(
      .DATA_W     (DATA_W),
      .FRAME_BITS (FRAME_BITS),
      .LEAD_ZEROS (LEAD_ZEROS)
   ) u_frame_shift (
      .clk      (clk),
      .reset_b  (reset_b),
      .clear    (quiet_last),
      .en       (shift_en),
      .sdata    (adc_sdata),
      .last_bit (last_bit),
      .lead_one (lead_one),
      .sample   (sample)
   );

   // State and all outputs are registered together: each transition sets
   // the outputs that belong to the state being entered.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= IDLE;
         quiet_cnt  <= '0;
         num_lat    <= '0;
         sample_cnt <= '0;
         cs         <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame_err  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         // Single-cycle strobes fall back to zero unless a transition
         // below raises them again.
         done  <= 1'b0;
         wr_en <= 1'b0;

         if (abort && (state != IDLE)) begin
            // Leave immediately; frame_err and wr_addr keep their values.
            state <= IDLE;
            cs    <= 1'b1;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !abort) begin
                     num_lat    <= num_samples;
                     sample_cnt <= '0;
                     wr_addr    <= '0;
                     frame_err  <= 1'b0;
                     quiet_cnt  <= '0;
                     busy       <= 1'b1;
                     if (num_samples == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= QUIET;
                     end
                  end
               end

               QUIET: begin
                  if (quiet_last) begin
                     state <= CONV;
                     cs    <= 1'b0;
                  end else begin
                     quiet_cnt <= quiet_cnt + QCNT_W'(1);
                  end
               end

               CONV: begin
                  if (lead_one) begin
                     frame_err <= 1'b1;
                  end
                  if (last_bit) begin
                     state   <= WRITE;
                     cs      <= 1'b1;
                     wr_en   <= 1'b1;
                     wr_data <= sample;
                  end
               end

               WRITE: begin
                  // Address wraps modulo 2^ADDR_W for bursts longer than
                  // the RAM.
                  wr_addr    <= wr_addr + ADDR_W'(1);
                  sample_cnt <= sample_cnt_inc;
                  quiet_cnt  <= '0;
                  if (sample_cnt_inc == num_lat) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= QUIET;
                  end
               end

               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end

               default: begin
                  state <= IDLE;
                  cs    <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
